stream_fifo_source: RTL and testbench

- Valid/ready elastic buffer sitting directly upstream of the sample design's stream input.
- Absorbs bursts from a producer (testbench driver or prior stage) and presents them as stream_in_valid/stream_in_data.
- Honours stream_in_ready backpressure from the consumer.
- Exposes its fill level for cocotb tests to check occupancy and backpressure.

---
 rtl/stream_fifo_pkg.sv | 11 +
 rtl/stream_fifo_mem.sv | 28 ++
 rtl/stream_fifo_source.sv | 129 ++++++++++++
 tb/tb_stream_fifo_source.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared defaults and helpers for the stream FIFO source buffer.
package stream_fifo_pkg;

    localparam int STREAM_DATA_WIDTH = 8;
    localparam int STREAM_FIFO_DEPTH = 4;

    function automatic int fifo_level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one write port, one registered read port, no reset.
module stream_fifo_mem #(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 4,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // A read of the slot being written returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stream_fifo_source.sv
// Valid/ready elastic buffer feeding a stream consumer, with fill level output.
// Optional pop counter (beat_count) enabled by defining STREAM_FIFO_STATS_EN.
module stream_fifo_source
    import stream_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH  = STREAM_DATA_WIDTH,
    parameter int  DEPTH       = STREAM_FIFO_DEPTH,
    localparam int LEVEL_WIDTH = fifo_level_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   stream_in_valid,
    input  logic                   stream_in_ready,
    output logic [DATA_WIDTH-1:0]  stream_in_data,
    output logic [LEVEL_WIDTH-1:0] level
`ifdef STREAM_FIFO_STATS_EN
    ,
    output logic [31:0]            beat_count
`endif
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [LEVEL_WIDTH-1:0] level_after_pop;
    logic                   valid_q, valid_d;
    logic                   byp_q, byp_d;
    logic [DATA_WIDTH-1:0]  byp_data_q, byp_data_d;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   push, pop;

    assign wr_ready = !rst && !flush && (level_q != LEVEL_WIDTH'(DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop      = valid_q && stream_in_ready && !flush;

    // The memory re-reads the next head every cycle; the bypass register covers
    // the one case where that slot is written on the same edge it becomes head.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        valid_d         = valid_q;
        byp_d           = byp_q;
        byp_data_d      = byp_data_q;
        level_after_pop = level_q - LEVEL_WIDTH'(pop);
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            valid_d    = 1'b0;
            byp_d      = 1'b1;
            byp_data_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            end
            level_d = level_after_pop + LEVEL_WIDTH'(push);
            valid_d = (level_d != '0);
            if (push && (level_after_pop == '0)) begin
                byp_d      = 1'b1;
                byp_data_d = wr_data;
            end else if (level_d != '0) begin
                byp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            byp_q      <= 1'b1;
            byp_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_d),
        .rdata (mem_rdata)
    );

    assign stream_in_valid = valid_q;
    assign stream_in_data  = byp_q ? byp_data_q : mem_rdata;
    assign level           = level_q;

`ifdef STREAM_FIFO_STATS_EN
    logic [31:0] beat_count_q, beat_count_d;

    always_comb begin
        beat_count_d = beat_count_q + 32'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count_d;
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_stream_fifo_source.sv
// Directed self-checking bench for stream_fifo_source (stats checks with STREAM_FIFO_STATS_EN).
module tb_stream_fifo_source;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       stream_in_valid;
    logic       stream_in_ready;
    logic [7:0] stream_in_data;
    logic [2:0] level;
`ifdef STREAM_FIFO_STATS_EN
    logic [31:0] beat_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    stream_fifo_source dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .stream_in_valid (stream_in_valid),
        .stream_in_ready (stream_in_ready),
        .stream_in_data  (stream_in_data),
        .level           (level)
`ifdef STREAM_FIFO_STATS_EN
        ,
        .beat_count      (beat_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; stream_in_ready = 1'b0;
        #1;
        check("ready_in_reset", 32'(wr_ready), 32'd0);
        tick();
        tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(stream_in_valid), 32'd0);
        check("rst_data", 32'(stream_in_data), 32'h00);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(wr_ready), 32'd1);
        tick();
        check("idle_level", 32'(level), 32'd0);
        check("idle_valid", 32'(stream_in_valid), 32'd0);

        // Fill to full under backpressure, then drain in order.
        push_one(8'h11); push_one(8'h22); push_one(8'h33); push_one(8'h44);
        check("full_level", 32'(level), 32'd4);
        check("full_ready", 32'(wr_ready), 32'd0);
        check("full_valid", 32'(stream_in_valid), 32'd1);
        check("stall_head", 32'(stream_in_data), 32'h11);
        tick();
        check("stall_hold", 32'(stream_in_data), 32'h11);
        stream_in_ready = 1'b1;
        check("drain_0", 32'(stream_in_data), 32'h11);
        tick();
        check("full_pop_ready", 32'(wr_ready), 32'd1);
        check("full_pop_level", 32'(level), 32'd3);
        check("drain_1", 32'(stream_in_data), 32'h22);
        tick();
        check("drain_2", 32'(stream_in_data), 32'h33);
        tick();
        check("drain_3", 32'(stream_in_data), 32'h44);
        tick();
        check("drained_valid", 32'(stream_in_valid), 32'd0);
        check("drained_level", 32'(level), 32'd0);
        stream_in_ready = 1'b0;

        // Simultaneous push and pop at level 2 across pointer wrap.
        push_one(8'hE0); push_one(8'hE1);
        exp_q.push_back(8'hE0); exp_q.push_back(8'hE1);
        check("pp_start_level", 32'(level), 32'd2);
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            stream_in_ready = 1'b1;
            check("pp_data", 32'(stream_in_data), 32'(exp_q.pop_front()));
            exp_q.push_back(8'(i));
            tick();
            check("pp_level", 32'(level), 32'd2);
        end
        wr_valid = 1'b0;
        check("pp_tail_8", 32'(stream_in_data), 32'h08);
        tick();
        check("pp_tail_9", 32'(stream_in_data), 32'h09);
        tick();
        check("pp_empty", 32'(stream_in_valid), 32'd0);
        stream_in_ready = 1'b0;
        exp_q.delete();

        // Flush wins over push and pop in the same cycle.
        push_one(8'h31); push_one(8'h32); push_one(8'h33);
        check("fl_pre_level", 32'(level), 32'd3);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hAA; stream_in_ready = 1'b1;
        #1;
        check("fl_ready", 32'(wr_ready), 32'd0);
        tick();
        flush = 1'b0; wr_valid = 1'b0;
        check("fl_level", 32'(level), 32'd0);
        check("fl_valid", 32'(stream_in_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_aa", 32'(stream_in_valid), 32'd0);
        end
        stream_in_ready = 1'b0;
        push_one(8'h77);
        check("fl_after_data", 32'(stream_in_data), 32'h77);
        stream_in_ready = 1'b1;
        tick();
        check("fl_after_empty", 32'(stream_in_valid), 32'd0);
        stream_in_ready = 1'b0;

        // Reset while full discards everything.
        push_one(8'h41); push_one(8'h42); push_one(8'h43); push_one(8'h44);
        check("rm_pre_level", 32'(level), 32'd4);
        rst = 1'b1;
        tick();
        check("rm_level", 32'(level), 32'd0);
        check("rm_valid", 32'(stream_in_valid), 32'd0);
        check("rm_data", 32'(stream_in_data), 32'h00);
        check("rm_ready_in_rst", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rm_ready_after", 32'(wr_ready), 32'd1);
        push_one(8'h5A);
        check("rm_5a_valid", 32'(stream_in_valid), 32'd1);
        check("rm_5a_data", 32'(stream_in_data), 32'h5A);
        check("rm_5a_level", 32'(level), 32'd1);
        stream_in_ready = 1'b1;
        tick();
        check("rm_5a_alone", 32'(stream_in_valid), 32'd0);
        stream_in_ready = 1'b0;

`ifdef STREAM_FIFO_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("bc_clear", beat_count, 32'd0);
        for (int i = 0; i < 7; i++) begin
            push_one(8'(8'h60 + i));
            stream_in_ready = 1'b1;
            tick();
            stream_in_ready = 1'b0;
        end
        check("bc_seven", beat_count, 32'd7);
        push_one(8'h6F);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_one(8'(8'h70 + i));
            stream_in_ready = 1'b1;
            tick();
            stream_in_ready = 1'b0;
        end
        check("bc_ten", beat_count, 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("bc_rst", beat_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
